// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one 8-bit ALU between requesters A and B.
// It holds the operands for the op's settle latency and returns the captured result on a backpressured channel.
module alu_arbiter #(
    parameter int unsigned LAT_ADD   = 2,
    parameter int unsigned LAT_LOGIC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [2:0] a_op,
    input  logic [7:0] a_d1,
    input  logic [7:0] a_d2,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [2:0] b_op,
    input  logic [7:0] b_d1,
    input  logic [7:0] b_d2,
    output logic [7:0] alu_data1,
    output logic [7:0] alu_data2,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_co,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_co,
    output logic       rsp_err,
    output logic       busy
);

    localparam int unsigned LAT_MAX = (LAT_ADD > LAT_LOGIC) ? LAT_ADD : LAT_LOGIC;
    localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_ADD   = CNT_W'(LAT_ADD - 1);
    localparam logic [CNT_W-1:0] CNT_LOGIC = CNT_W'(LAT_LOGIC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [2:0]       OP_ADD    = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       alu_data1_q;
    logic [7:0]       alu_data2_q;
    logic [2:0]       alu_op_q;
    logic             rsp_id_q;
    logic [7:0]       rsp_result_q;
    logic             rsp_co_q;
    logic             rsp_err_q;

    logic             any_req_s;
    logic             win_b_s;
    logic [2:0]       sel_op_s;
    logic [7:0]       sel_d1_s;
    logic [7:0]       sel_d2_s;
    logic [CNT_W-1:0] sel_cnt_s;

    // Winner selection and operand mux; on a tie the requester not granted last time wins
    always_comb begin
        any_req_s = a_valid | b_valid;
        win_b_s   = b_valid & (~a_valid | ~last_grant_q);
        a_ready   = (state_q == ST_IDLE) & a_valid & ~win_b_s;
        b_ready   = (state_q == ST_IDLE) & win_b_s;
        if (win_b_s) begin
            sel_op_s = b_op;
            sel_d1_s = b_d1;
            sel_d2_s = b_d2;
        end else begin
            sel_op_s = a_op;
            sel_d1_s = a_d1;
            sel_d2_s = a_d2;
        end
        if (sel_op_s == OP_ADD) begin
            sel_cnt_s = CNT_ADD;
        end else begin
            sel_cnt_s = CNT_LOGIC;
        end
    end

    // Sequencer: accept in IDLE, hold operands for the settle latency in EXEC, present the response in RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= CNT_ZERO;
            alu_data1_q  <= 8'h00;
            alu_data2_q  <= 8'h00;
            alu_op_q     <= 3'b000;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 8'h00;
            rsp_co_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        alu_data1_q  <= sel_d1_s;
                        alu_data2_q  <= sel_d2_s;
                        alu_op_q     <= sel_op_s;
                        rsp_id_q     <= win_b_s;
                        last_grant_q <= win_b_s;
                        cnt_q        <= sel_cnt_s;
                        // Ops 1xx never reach the ALU result path: answer immediately with an error
                        if (sel_op_s[2]) begin
                            rsp_result_q <= 8'h00;
                            rsp_co_q     <= 1'b0;
                            rsp_err_q    <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            state_q      <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        rsp_result_q <= alu_result;
                        rsp_co_q     <= alu_co;
                        rsp_err_q    <= 1'b0;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_data1  = alu_data1_q;
    assign alu_data2  = alu_data2_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_co     = rsp_co_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// A behavioural ALU that shows inverted data until its inputs have settled sits behind each DUT.
module tb_alu_arbiter;

    localparam int LA1 = 2;
    localparam int LA4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_n, a_valid, b_valid, rsp_ready;
    logic [2:0] a_op, b_op;
    logic [7:0] a_d1, a_d2, b_d1, b_d2;
    logic       a_ready, b_ready, alu_co, rsp_valid, rsp_id, rsp_co, rsp_err, busy;
    logic [7:0] alu_data1, alu_data2, alu_result, rsp_result;
    logic [2:0] alu_op;

    logic       a4_valid, rsp4_ready;
    logic [2:0] a4_op;
    logic [7:0] a4_d1, a4_d2;
    logic       a4_ready, b4_ready, alu4_co, rsp4_valid, rsp4_id, rsp4_co, rsp4_err, busy4;
    logic [7:0] alu4_data1, alu4_data2, alu4_result, rsp4_result;
    logic [2:0] alu4_op;

    alu_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_d1(a_d1), .a_d2(a_d2),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_d1(b_d1), .b_d2(b_d2),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_co(alu_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_co(rsp_co), .rsp_err(rsp_err), .busy(busy)
    );

    alu_arbiter #(.LAT_ADD(LA4), .LAT_LOGIC(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a4_valid), .a_ready(a4_ready), .a_op(a4_op), .a_d1(a4_d1), .a_d2(a4_d2),
        .b_valid(1'b0), .b_ready(b4_ready), .b_op(3'b000), .b_d1(8'h00), .b_d2(8'h00),
        .alu_data1(alu4_data1), .alu_data2(alu4_data2), .alu_op(alu4_op),
        .alu_result(alu4_result), .alu_co(alu4_co),
        .rsp_valid(rsp4_valid), .rsp_ready(rsp4_ready), .rsp_id(rsp4_id),
        .rsp_result(rsp4_result), .rsp_co(rsp4_co), .rsp_err(rsp4_err), .busy(busy4)
    );

    function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] d1, input logic [7:0] d2);
        case (op)
            3'b000:  return {1'b0, d2};
            3'b001:  return {1'b0, d1} + {1'b0, d2};
            3'b010:  return {1'b0, d1 & d2};
            3'b011:  return {1'b0, d1 | d2};
            default: return 9'h000;
        endcase
    endfunction

    function automatic int settle(input logic [2:0] op, input int lat_add);
        return (op == 3'b001) ? lat_add : 1;
    endfunction

    // ALU environment: count cycles its inputs have been stable; garbage until settled
    logic [18:0] snap1, snap4;
    int          sc1 = 0, sc4 = 0;
    always @(negedge clk) begin
        if ({alu_op, alu_data1, alu_data2} !== snap1) begin
            snap1 <= {alu_op, alu_data1, alu_data2};
            sc1   <= 1;
        end else if (sc1 < 1000) begin
            sc1 <= sc1 + 1;
        end
        if ({alu4_op, alu4_data1, alu4_data2} !== snap4) begin
            snap4 <= {alu4_op, alu4_data1, alu4_data2};
            sc4   <= 1;
        end else if (sc4 < 1000) begin
            sc4 <= sc4 + 1;
        end
    end

    always_comb begin
        if (sc1 >= settle(alu_op, LA1)) {alu_co, alu_result} = alu_ref(alu_op, alu_data1, alu_data2);
        else                            {alu_co, alu_result} = ~alu_ref(alu_op, alu_data1, alu_data2);
        if (sc4 >= settle(alu4_op, LA4)) {alu4_co, alu4_result} = alu_ref(alu4_op, alu4_data1, alu4_data2);
        else                             {alu4_co, alu4_result} = ~alu_ref(alu4_op, alu4_data1, alu4_data2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a4_valid = 1'b0;
        rsp_ready = 1'b0; rsp4_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; a_op = 3'b001; a_d1 = 8'hAA; a_d2 = 8'h55;
        b_valid = 1'b1; b_op = 3'b011; b_d1 = 8'h11; b_d2 = 8'h22; rsp_ready = 1'b1;
        step();
        checks++;
        if ({busy, rsp_valid, rsp_id, rsp_co, rsp_err, rsp_result, alu_op, alu_data1, alu_data2} !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {busy, rsp_valid, rsp_id, rsp_co, rsp_err, rsp_result, alu_op, alu_data1, alu_data2});
        end
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_add_basic();
        int n;
        rsp_ready = 1'b1; a_valid = 1'b1; a_op = 3'b001; a_d1 = 8'hF0; a_d2 = 8'h20; b_valid = 1'b0;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL add_ready got %b exp 10", {a_ready, b_ready});
        end
        step();
        a_valid = 1'b0;
        checks++;
        if ({busy, alu_op, alu_data1, alu_data2} !== {1'b1, 3'b001, 8'hF0, 8'h20}) begin
            errors++; $display("FAIL add_alu_drive got %h", {busy, alu_op, alu_data1, alu_data2});
        end
        n = 1;
        while (!rsp_valid && n < 20) begin step(); n++; end
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL add_latency got %0d exp 3", n);
        end
        checks++;
        if ({rsp_id, rsp_co, rsp_err, rsp_result} !== {1'b0, 1'b1, 1'b0, 8'h10}) begin
            errors++; $display("FAIL add_rsp got id%b co%b err%b %h exp id0 co1 err0 10", rsp_id, rsp_co, rsp_err, rsp_result);
        end
        step();
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL add_release got %b exp 00", {busy, rsp_valid});
        end
    endtask

    task automatic test_tie();
        int  n;
        logic exp_b;
        reset_dut();
        rsp_ready = 1'b1;
        a_valid = 1'b1; a_op = 3'b010; a_d1 = 8'h0F; a_d2 = 8'h3C;
        b_valid = 1'b1; b_op = 3'b011; b_d1 = 8'h01; b_d2 = 8'h02;
        #1;
        for (int g = 0; g < 6; g++) begin
            exp_b = (g % 2) == 1;
            n = 0;
            while (!(a_ready || b_ready) && n < 20) begin step(); n++; end
            checks++;
            if ({a_ready, b_ready} !== {~exp_b, exp_b}) begin
                errors++; $display("FAIL tie_grant%0d got %b exp %b", g, {a_ready, b_ready}, {~exp_b, exp_b});
            end
            step();
            n = 0;
            while (!rsp_valid && n < 20) begin step(); n++; end
            checks++;
            if ({rsp_valid, rsp_id, rsp_co, rsp_err, rsp_result} !== {1'b1, exp_b, 1'b0, 1'b0, exp_b ? 8'h03 : 8'h0C}) begin
                errors++; $display("FAIL tie_rsp%0d got v%b id%b co%b err%b %h", g, rsp_valid, rsp_id, rsp_co, rsp_err, rsp_result);
            end
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        int n;
        rsp_ready = 1'b0; a_valid = 1'b0;
        b_valid = 1'b1; b_op = 3'b000; b_d1 = 8'hC3; b_d2 = 8'h5A;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_ready got %b exp 01", {a_ready, b_ready});
        end
        step();
        b_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin step(); n++; end
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL fwd_latency got %0d exp 2", n);
        end
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin rsp_ready = 1'b1; #1; end
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, a_ready, b_ready} !== {1'b1, 1'b1, 8'h5A, 1'b0, 1'b0}) begin
                errors++; $display("FAIL bp_hold%0d got v%b id%b %h rdy%b%b", k, rsp_valid, rsp_id, rsp_result, a_ready, b_ready);
            end
            step();
        end
        checks++;
        if ({busy, rsp_valid, a_ready, b_ready} !== 4'b0010) begin
            errors++; $display("FAIL bp_idle got %b exp 0010", {busy, rsp_valid, a_ready, b_ready});
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        rsp_ready = 1'b0; a_valid = 1'b1; a_op = 3'b110; a_d1 = 8'h12; a_d2 = 8'h34;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL ill_ready got %b exp 1", a_ready);
        end
        step();
        a_valid = 1'b0;
        checks++;
        if ({rsp_valid, busy, rsp_err, rsp_co, rsp_id, rsp_result, alu_op} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'b110}) begin
            errors++; $display("FAIL ill_rsp got v%b err%b co%b id%b %h op%b", rsp_valid, rsp_err, rsp_co, rsp_id, rsp_result, alu_op);
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if ({busy, rsp_valid} !== 2'b00) begin
            errors++; $display("FAIL ill_release got %b exp 00", {busy, rsp_valid});
        end
    endtask

    task automatic test_reset_mid_exec();
        rsp_ready = 1'b1; a_valid = 1'b1; a_op = 3'b001; a_d1 = 8'h80; a_d2 = 8'h80;
        step();
        a_valid = 1'b0;
        step();
        checks++;
        if ({busy, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL mid_exec got %b exp 10", {busy, rsp_valid});
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({busy, rsp_valid, rsp_id, rsp_co, rsp_err, rsp_result, alu_op, alu_data1, alu_data2} !== 32'h0) begin
            errors++; $display("FAIL mid_reset got %h exp 0", {busy, rsp_valid, rsp_id, rsp_co, rsp_err, rsp_result, alu_op, alu_data1, alu_data2});
        end
        rst_n = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++; $display("FAIL mid_tie got %b exp 10", {a_ready, b_ready});
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_lat4();
        int n;
        rsp4_ready = 1'b1; a4_valid = 1'b1; a4_op = 3'b001; a4_d1 = 8'hFF; a4_d2 = 8'h01;
        #1;
        checks++;
        if (a4_ready !== 1'b1) begin
            errors++; $display("FAIL lat4_ready got %b exp 1", a4_ready);
        end
        step();
        a4_valid = 1'b0;
        n = 1;
        while (!rsp4_valid && n < 30) begin step(); n++; end
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL lat4_latency got %0d exp 5", n);
        end
        checks++;
        if ({rsp4_id, rsp4_co, rsp4_err, rsp4_result} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL lat4_rsp got id%b co%b err%b %h", rsp4_id, rsp4_co, rsp4_err, rsp4_result);
        end
        step();
    endtask

    function automatic logic [2:0] rand_op();
        if ($urandom_range(0, 9) == 0) return 3'b100 | 3'($urandom_range(0, 3));
        return 3'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic       m_busy, m_resp, m_last, m_id, m_co, m_err, p_co, win, win_b;
        logic [7:0] m_res, p_res, m_d1, m_d2;
        logic [2:0] m_op;
        int         m_wait;
        logic [8:0] r;
        reset_dut();
        m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b1; m_id = 1'b0; m_co = 1'b0; m_err = 1'b0;
        m_res = 8'h00; m_d1 = 8'h00; m_d2 = 8'h00; m_op = 3'b000; m_wait = 0;
        p_res = 8'h00; p_co = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++;
            if ({busy, rsp_valid} !== {m_busy, m_resp}) begin
                errors++; $display("FAIL rnd_state c%0d got %b exp %b", cyc, {busy, rsp_valid}, {m_busy, m_resp});
            end
            checks++;
            if ({rsp_id, rsp_co, rsp_err, rsp_result} !== {m_id, m_co, m_err, m_res}) begin
                errors++; $display("FAIL rnd_rsp c%0d got %h exp %h", cyc, {rsp_id, rsp_co, rsp_err, rsp_result}, {m_id, m_co, m_err, m_res});
            end
            checks++;
            if ({alu_op, alu_data1, alu_data2} !== {m_op, m_d1, m_d2}) begin
                errors++; $display("FAIL rnd_alu c%0d got %h exp %h", cyc, {alu_op, alu_data1, alu_data2}, {m_op, m_d1, m_d2});
            end
            a_valid = 1'($urandom_range(0, 1)); a_op = rand_op(); a_d1 = 8'($urandom); a_d2 = 8'($urandom);
            b_valid = 1'($urandom_range(0, 1)); b_op = rand_op(); b_d1 = 8'($urandom); b_d2 = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            win = 1'b0; win_b = 1'b0;
            if (!m_busy) begin
                if (a_valid && b_valid) begin win = 1'b1; win_b = ~m_last; end
                else if (a_valid)       begin win = 1'b1; win_b = 1'b0; end
                else if (b_valid)       begin win = 1'b1; win_b = 1'b1; end
            end
            checks++;
            if ({a_ready, b_ready} !== {win & ~win_b, win & win_b}) begin
                errors++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, {a_ready, b_ready}, {win & ~win_b, win & win_b});
            end
            if (win) begin
                m_busy = 1'b1; m_id = win_b; m_last = win_b;
                m_op = win_b ? b_op : a_op;
                m_d1 = win_b ? b_d1 : a_d1;
                m_d2 = win_b ? b_d2 : a_d2;
                if (m_op[2]) begin
                    m_resp = 1'b1; m_res = 8'h00; m_co = 1'b0; m_err = 1'b1;
                end else begin
                    r = alu_ref(m_op, m_d1, m_d2);
                    p_res = r[7:0]; p_co = r[8];
                    m_wait = settle(m_op, LA1);
                end
            end else if (m_busy && m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_resp = 1'b1; m_res = p_res; m_co = p_co; m_err = 1'b0;
                end
            end else if (m_resp && rsp_ready) begin
                m_resp = 1'b0; m_busy = 1'b0;
            end
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not complete");
    end

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b0;
        a_op = 3'b000; b_op = 3'b000; a_d1 = 8'h00; a_d2 = 8'h00; b_d1 = 8'h00; b_d2 = 8'h00;
        a4_valid = 1'b0; rsp4_ready = 1'b0; a4_op = 3'b000; a4_d1 = 8'h00; a4_d2 = 8'h00;
        test_reset();
        test_add_basic();
        test_tie();
        test_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_lat4();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
